// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer feeding the IF/ID register.
// Owns the PC, keeps at most one instruction-memory request in flight, and
// holds one fetched instruction in a skid buffer. Handles IF/ID stalls and
// EX-stage redirects, discarding any response that belongs to a flushed path.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_inst
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] infl_pc;
   logic        buf_valid;
   logic [31:0] buf_pc;
   logic [31:0] buf_inst;

   logic        consume;
   logic        buf_free;
   logic        redir;
   logic        grant;
   logic        load;

   // The buffer can accept a new word if it is empty or drains this cycle.
   assign consume  = buf_valid & ~stall;
   assign buf_free = ~buf_valid | consume;
   // Redirects are ignored during the post-reset IDLE cycle.
   assign redir    = redirect & (state != IDLE);
   assign grant    = imem_req & imem_gnt;
   // A response is only kept if it arrives in WAIT and is not flushed.
   assign load     = (state == WAIT) & imem_rvalid & ~redir;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a redirect turns any in-flight request into one to drain.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  state_next = REQ;
         REQ: begin
            if (grant) begin
               state_next = redir ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_next = REQ;
            end else if (redir) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rvalid) begin
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: request only when the buffer will have room for the answer.
   always_comb begin
      imem_req    = (state == REQ) & buf_free;
      imem_addr   = {pc[31:2], 2'b00};
      fetch_valid = buf_valid;
      fetch_pc    = buf_pc;
      fetch_inst  = buf_valid ? buf_inst : NOP_INST;
   end

   // PC and in-flight address; a redirect overrides the sequential increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         infl_pc <= RESET_PC;
      end else begin
         if (grant) begin
            infl_pc <= pc;
         end
         if (redir) begin
            pc <= redirect_pc & ~32'h0000_0003;
         end else if (grant) begin
            pc <= pc + 32'd4;
         end
      end
   end

   // Skid buffer: flush on redirect, load on a live response, clear on consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_pc    <= 32'h0000_0000;
         buf_inst  <= NOP_INST;
      end else if (redir) begin
         buf_valid <= 1'b0;
         buf_inst  <= NOP_INST;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_pc    <= infl_pc;
         buf_inst  <= imem_rdata;
      end else if (consume) begin
         buf_valid <= 1'b0;
         buf_inst  <= NOP_INST;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. A small memory model answers
// granted requests after a programmable latency; answers that a redirect or
// reset makes stale are not expected. Live answers are pushed to a scoreboard
// and popped when IF/ID takes the buffered instruction.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;

   fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .fetch_inst  (fetch_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests;
   int          fails;
   int          cyc;
   int          lat;
   int          pend_cnt;
   bit          pend;
   bit          pend_stale;
   logic [31:0] pend_addr;
   logic [63:0] sb[$];
   logic [31:0] gnt_addr_q[$];
   int          gnt_cyc_q[$];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hA5C3_0F00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive the memory response for this cycle, then let outputs settle.
   task automatic pre();
      imem_rvalid = pend && (pend_cnt == 0);
      imem_rdata  = imem_rvalid ? inst_of(pend_addr) : 32'hDEAD_BEEF;
      #1;
   endtask

   // Scoreboard and memory bookkeeping for this cycle, then advance.
   task automatic post();
      logic [63:0] e;
      if (fetch_valid && (!stall || redirect)) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL sb_extra: observed fetch_pc %h expected no instruction", fetch_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!stall) begin
               chk("sb_pc", fetch_pc, e[63:32]);
               chk("sb_inst", fetch_inst, e[31:0]);
            end
         end
      end
      if (imem_rvalid) begin
         if (!pend_stale && !redirect && rst_n)
            sb.push_back({pend_addr, inst_of(pend_addr)});
         pend = 1'b0;
      end else if (pend) begin
         if (redirect || !rst_n) pend_stale = 1'b1;
         pend_cnt--;
      end
      if (!rst_n) sb.delete();
      if (imem_req && imem_gnt && rst_n) begin
         pend       = 1'b1;
         pend_addr  = imem_addr;
         pend_cnt   = lat - 1;
         pend_stale = redirect;
         gnt_addr_q.push_back(imem_addr);
         gnt_cyc_q.push_back(cyc);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic cycle();
      pre();
      post();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_addr"}, imem_addr, RESET_PC);
      chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
      chk({tag, "_pc"}, fetch_pc, 32'd0);
      chk({tag, "_inst"}, fetch_inst, NOP_INST);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; cyc = 0; lat = 1;
      pend = 1'b0; pend_stale = 1'b0; pend_cnt = 0; pend_addr = '0;
      rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

      // Reset values.
      @(negedge clk);
      pre(); chk_reset("rst"); post();
      rst_n = 1'b1;

      // Test 1: IDLE for one cycle, then a request every two cycles.
      pre(); chk("idle_req", {31'd0, imem_req}, 32'd0); post();
      repeat (4) cycle();

      // Test 2: stall holds the buffered instruction at 0x4 for five cycles.
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pre();
         chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
         chk("stall_pc", fetch_pc, 32'h4);
         chk("stall_inst", fetch_inst, inst_of(32'h4));
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         post();
      end
      stall = 1'b0;
      pre();
      chk("unstall_req", {31'd0, imem_req}, 32'd1);
      chk("unstall_addr", imem_addr, 32'h8);
      post();
      chk("t1_gnt0", gnt_addr_q[0], 32'h0);
      chk("t1_gnt1", gnt_addr_q[1], 32'h4);
      chk("t1_gnt2", gnt_addr_q[2], 32'h8);
      chk("t1_gap", gnt_cyc_q[1] - gnt_cyc_q[0], 32'd2);
      cycle();

      // Test 3: redirect while waiting; the late response is drained.
      lat = 3;
      cycle();
      redirect = 1'b1; redirect_pc = 32'h100;
      cycle();
      redirect = 1'b0;
      pre();
      chk("drain_valid", {31'd0, fetch_valid}, 32'd0);
      chk("drain_req", {31'd0, imem_req}, 32'd0);
      post();
      pre(); chk("drain_req2", {31'd0, imem_req}, 32'd0); post();
      lat = 1;
      pre();
      chk("t3_req", {31'd0, imem_req}, 32'd1);
      chk("t3_addr", imem_addr, 32'h100);
      chk("t3_valid", {31'd0, fetch_valid}, 32'd0);
      post();
      cycle();
      pre();
      chk("t3_fvalid", {31'd0, fetch_valid}, 32'd1);
      chk("t3_fpc", fetch_pc, 32'h100);
      post();

      // Test 4: redirect together with rvalid under stall; no drain.
      redirect = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
      cycle();
      redirect = 1'b0;
      pre();
      chk("t4_valid", {31'd0, fetch_valid}, 32'd0);
      chk("t4_req", {31'd0, imem_req}, 32'd1);
      chk("t4_addr", imem_addr, 32'h200);
      post();
      cycle();
      // Full buffer under stall, flushed by a misaligned redirect.
      redirect = 1'b1; redirect_pc = 32'h302;
      pre();
      chk("t4_full_valid", {31'd0, fetch_valid}, 32'd1);
      chk("t4_full_pc", fetch_pc, 32'h200);
      chk("t4_full_req", {31'd0, imem_req}, 32'd0);
      post();
      redirect = 1'b0;

      // Test 5: grant withheld; request and address hold, redirect retargets.
      stall = 1'b0; imem_gnt = 1'b0;
      pre();
      chk("t4_flush_valid", {31'd0, fetch_valid}, 32'd0);
      chk("t4_flush_inst", fetch_inst, NOP_INST);
      chk("t5_req0", {31'd0, imem_req}, 32'd1);
      chk("t5_addr0", imem_addr, 32'h300);
      post();
      pre();
      chk("t5_req1", {31'd0, imem_req}, 32'd1);
      chk("t5_addr1", imem_addr, 32'h300);
      post();
      redirect = 1'b1; redirect_pc = 32'h40;
      pre();
      chk("t5_req2", {31'd0, imem_req}, 32'd1);
      chk("t5_addr2", imem_addr, 32'h300);
      post();
      redirect = 1'b0;
      pre();
      chk("t5_req3", {31'd0, imem_req}, 32'd1);
      chk("t5_addr3", imem_addr, 32'h40);
      post();
      imem_gnt = 1'b1; lat = 2;
      cycle();

      // Test 6: reset pulse mid-WAIT; the late response is ignored.
      rst_n = 1'b0;
      pre(); chk_reset("t6_rst"); post();
      rst_n = 1'b1;
      lat = 1;
      pre();
      chk("t6_idle_valid", {31'd0, fetch_valid}, 32'd0);
      chk("t6_idle_req", {31'd0, imem_req}, 32'd0);
      post();
      pre();
      chk("t6_req", {31'd0, imem_req}, 32'd1);
      chk("t6_addr", imem_addr, RESET_PC);
      post();
      cycle();
      pre();
      chk("t6_fvalid", {31'd0, fetch_valid}, 32'd1);
      chk("t6_fpc", fetch_pc, RESET_PC);
      post();

      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
